// File: rtl/hack_pkg.sv
// Shared types and instruction-field positions for the Hack CPU sequencer.
package hack_pkg;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 15;

    localparam int IS_C     = 15;
    localparam int ABIT     = 12;
    localparam int COMP_MSB = 11;
    localparam int COMP_LSB = 6;
    localparam int DEST_A   = 5;
    localparam int DEST_D   = 4;
    localparam int DEST_M   = 3;
    localparam int JMP_LT   = 2;
    localparam int JMP_EQ   = 1;
    localparam int JMP_GT   = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        MEM_RD,
        EXEC,
        MEM_WR,
        HALT
    } state_t;
endpackage

// File: rtl/hack_jump_eval.sv
// Combinational Hack jump-condition evaluator: j1/j2/j3 against ALU flags.
module hack_jump_eval
    import hack_pkg::*;
(
    input  logic [2:0] jbits,
    input  logic       zr,
    input  logic       ng,
    output logic       jmp
);
    assign jmp = (jbits[JMP_LT] & ng) |
                 (jbits[JMP_EQ] & zr) |
                 (jbits[JMP_GT] & ~ng & ~zr);
endmodule

// File: rtl/hack_cpu_seq.sv
// Multi-cycle Hack CPU sequencer: fetch/decode/mem/exec over req/ack ports,
// drives the external combinational Hack ALU and holds A, D and PC.
module hack_cpu_seq
    import hack_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    input  logic              rom_ack,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic [WORD_W-1:0] alu_x,
    output logic [WORD_W-1:0] alu_y,
    output logic              alu_zx,
    output logic              alu_nx,
    output logic              alu_zy,
    output logic              alu_ny,
    output logic              alu_f,
    output logic              alu_no,
    input  logic [WORD_W-1:0] alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic [ADDR_W-1:0] pc,
    output logic [WORD_W-1:0] a_reg,
    output logic [WORD_W-1:0] d_reg,
    output logic              retired,
    output logic              halted,
    output logic              err
);
    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   ir_q, m_q, r_q;
    logic [ADDR_W-1:0]   old_a_q, prev_pc_q, jmp_tgt;
    logic                zr_q, ng_q, prev_a_q;
    logic [WDW-1:0]      wd_q;
    logic                wait_st, wd_exp, a_done, c_done, self_loop, timeout;
    logic                jmp, jz, jn;
    logic [5:0]          alu_ctrl;
    logic [1:0]          unused_ir;

    assign unused_ir = ir_q[14:13];

    // Completion in EXEC sees the live ALU flags and pre-write A; in MEM_WR the captured copies.
    assign jz      = (state_q == EXEC) ? alu_zr : zr_q;
    assign jn      = (state_q == EXEC) ? alu_ng : ng_q;
    assign jmp_tgt = (state_q == EXEC) ? a_reg[ADDR_W-1:0] : old_a_q;

    hack_jump_eval u_jump (
        .jbits (ir_q[JMP_LT:JMP_GT]),
        .zr    (jz),
        .ng    (jn),
        .jmp   (jmp)
    );

    assign wait_st = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign wd_exp  = (TIMEOUT != 0) && (wd_q == WDW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        a_done    = 1'b0;
        c_done    = 1'b0;
        self_loop = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE:   if (run) state_d = FETCH;
            FETCH: begin
                if (rom_ack)     state_d = DECODE;
                else if (wd_exp) begin state_d = HALT; timeout = 1'b1; end
            end
            DECODE: begin
                if (!ir_q[IS_C]) begin
                    a_done  = 1'b1;
                    state_d = run ? FETCH : IDLE;
                end else begin
                    state_d = ir_q[ABIT] ? MEM_RD : EXEC;
                end
            end
            MEM_RD: begin
                if (ram_ack)     state_d = EXEC;
                else if (wd_exp) begin state_d = HALT; timeout = 1'b1; end
            end
            EXEC: begin
                if (ir_q[DEST_M]) state_d = MEM_WR;
                else              c_done  = 1'b1;
            end
            MEM_WR: begin
                if (ram_ack)     c_done = 1'b1;
                else if (wd_exp) begin state_d = HALT; timeout = 1'b1; end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        if (c_done) begin
            // "@n ; 0;JMP" pattern: a jump straight back onto the preceding A-instruction
            if (jmp && prev_a_q && (jmp_tgt == prev_pc_q)) begin
                self_loop = 1'b1;
                state_d   = HALT;
            end else begin
                state_d = run ? FETCH : IDLE;
            end
        end
    end

    assign rom_req   = (state_q == FETCH);
    assign rom_addr  = pc;
    assign ram_req   = (state_q == MEM_RD) || (state_q == MEM_WR);
    assign ram_we    = (state_q == MEM_WR);
    assign ram_addr  = (state_q == MEM_WR) ? old_a_q :
                       (state_q == MEM_RD) ? a_reg[ADDR_W-1:0] : '0;
    assign ram_wdata = (state_q == MEM_WR) ? r_q : '0;
    assign alu_x     = (state_q == EXEC) ? d_reg : '0;
    assign alu_y     = (state_q != EXEC) ? '0 : (ir_q[ABIT] ? m_q : a_reg);
    assign alu_ctrl  = (state_q == EXEC) ? ir_q[COMP_MSB:COMP_LSB] : 6'd0;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = alu_ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            m_q       <= '0;
            r_q       <= '0;
            old_a_q   <= '0;
            prev_pc_q <= '0;
            zr_q      <= 1'b0;
            ng_q      <= 1'b0;
            prev_a_q  <= 1'b0;
            wd_q      <= '0;
            pc        <= '0;
            a_reg     <= '0;
            d_reg     <= '0;
            retired   <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q <= state_d;
            retired <= a_done | c_done;
            if (self_loop) halted <= 1'b1;
            if (timeout)   err    <= 1'b1;
            if ((state_d != state_q) || !wait_st) wd_q <= '0;
            else                                  wd_q <= wd_q + WDW'(1);
            if ((state_q == FETCH) && rom_ack)  ir_q <= rom_data;
            if ((state_q == MEM_RD) && ram_ack) m_q  <= ram_rdata;
            if (state_q == EXEC) begin
                r_q     <= alu_out;
                zr_q    <= alu_zr;
                ng_q    <= alu_ng;
                old_a_q <= a_reg[ADDR_W-1:0];
                if (ir_q[DEST_A]) a_reg <= alu_out;
                if (ir_q[DEST_D]) d_reg <= alu_out;
            end
            if (a_done) begin
                a_reg     <= ir_q;
                pc        <= pc + ADDR_W'(1);
                prev_a_q  <= 1'b1;
                prev_pc_q <= pc;
            end
            if (c_done) begin
                pc       <= jmp ? jmp_tgt : pc + ADDR_W'(1);
                prev_a_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hack_cpu_seq.sv
// Directed bench for hack_cpu_seq with ROM/RAM responders and a Hack ALU model.
module tb_hack_cpu_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        rom_req, ram_req, ram_we;
    logic [14:0] rom_addr, ram_addr, pc;
    logic [15:0] rom_data = 16'h0;
    logic        rom_ack = 1'b0;
    logic [15:0] ram_wdata, ram_rdata;
    logic        ram_ack = 1'b0;
    logic [15:0] alu_x, alu_y, alu_out, a_reg, d_reg;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
    logic        retired, halted, err;

    logic [15:0] rom [0:31];
    bit          rom_en = 1'b1;
    int          ram_lat = 0;
    int          ram_cnt = 0;
    logic [15:0] ram_val = 16'h0;
    logic [14:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    hack_cpu_seq #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .run(run),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ack(rom_ack),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
        .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .pc(pc), .a_reg(a_reg), .d_reg(d_reg),
        .retired(retired), .halted(halted), .err(err)
    );

    // Reference Hack ALU
    logic [15:0] ax, ay, ar;
    always_comb begin
        ax = alu_zx ? 16'h0 : alu_x;
        if (alu_nx) ax = ~ax;
        ay = alu_zy ? 16'h0 : alu_y;
        if (alu_ny) ay = ~ay;
        ar = alu_f ? ax + ay : ax & ay;
        if (alu_no) ar = ~ar;
    end
    assign alu_out   = ar;
    assign alu_zr    = (ar == 16'h0);
    assign alu_ng    = ar[15];
    assign ram_rdata = ram_val;

    // ROM acks one cycle after req; RAM adds ram_lat extra wait cycles
    always @(posedge clk) begin
        rom_ack  <= rom_req && !rom_ack && rom_en;
        rom_data <= rom[rom_addr[4:0]];
        if (ram_req && !ram_ack) begin
            if (ram_cnt >= ram_lat) begin
                ram_ack <= 1'b1;
                ram_cnt <= 0;
            end else begin
                ram_cnt <= ram_cnt + 1;
            end
        end else begin
            ram_ack <= 1'b0;
            ram_cnt <= 0;
        end
        if (ram_req && ram_we && ram_ack) begin
            wr_addr <= ram_addr;
            wr_data <= ram_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 16'h0;
    endtask

    task automatic do_reset();
        run   = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_retire(input int max, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            n++;
            if (retired === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_n(input int k, output bit ok);
        bit o;
        int n;
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
            wait_retire(20, o, n);
            if (!o) ok = 1'b0;
        end
    endtask

    task automatic wait_ram_req(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (ram_req === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [5:0] ctl;
        reset = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        ctl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
        checks++; if ({rom_req, ram_req, ram_we, retired, halted, err} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b exp 000000", {rom_req, ram_req, ram_we, retired, halted, err}); end
        checks++; if ({pc, rom_addr, ram_addr} !== 45'h0) begin
            errors++; $display("FAIL reset_addr: pc %h rom_addr %h ram_addr %h exp 0", pc, rom_addr, ram_addr); end
        checks++; if ({a_reg, d_reg, ram_wdata} !== 48'h0) begin
            errors++; $display("FAIL reset_regs: a %h d %h wdata %h exp 0", a_reg, d_reg, ram_wdata); end
        checks++; if ({alu_x, alu_y, ctl} !== 38'h0) begin
            errors++; $display("FAIL reset_alu: x %h y %h ctl %b exp 0", alu_x, alu_y, ctl); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rom_req !== 1'b0) begin
            errors++; $display("FAIL idle_no_run: rom_req got %b exp 0", rom_req); end
    endtask

    task automatic test_a_instr();
        clear_rom();
        rom[0] = 16'h0005; rom[1] = 16'hEDD0; rom[2] = 16'h0064; rom[3] = 16'hE308;
        ram_lat = 0;
        do_reset();
        run = 1'b1;
        @(negedge clk);
        checks++; if ({rom_req, rom_addr} !== {1'b1, 15'h0}) begin
            errors++; $display("FAIL a_fetch: req/addr got %b/%h exp 1/0", rom_req, rom_addr); end
        @(negedge clk);
        @(negedge clk);
        checks++; if ({rom_req, retired} !== 2'b00) begin
            errors++; $display("FAIL a_decode: req/retired got %b exp 00", {rom_req, retired}); end
        @(negedge clk);
        checks++; if ({retired, a_reg, pc} !== {1'b1, 16'h0005, 15'h0001}) begin
            errors++; $display("FAIL a_retire: ret %b a %h pc %h exp 1 0005 0001", retired, a_reg, pc); end
    endtask

    task automatic test_alu_ctrl();
        logic [5:0] ctl;
        bit ok;
        int n;
        ctl = 6'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ctl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
            if (ctl != 6'h0) break;
        end
        checks++; if (ctl !== 6'b110111) begin
            errors++; $display("FAIL alu_ctl: got %b exp 110111", ctl); end
        checks++; if ({alu_x, alu_y} !== {16'h0000, 16'h0005}) begin
            errors++; $display("FAIL alu_ops: x %h y %h exp 0000 0005", alu_x, alu_y); end
        wait_retire(10, ok, n);
        checks++; if ({ok, d_reg, pc} !== {1'b1, 16'h0006, 15'h0002}) begin
            errors++; $display("FAIL alu_result: ok %b d %h pc %h exp 1 0006 0002", ok, d_reg, pc); end
    endtask

    task automatic test_mem_write();
        bit ok;
        bit stable;
        int n;
        ram_lat = 2;
        wait_retire(10, ok, n);
        checks++; if ({ok, a_reg, pc} !== {1'b1, 16'h0064, 15'h0003}) begin
            errors++; $display("FAIL mw_at: ok %b a %h pc %h exp 1 0064 0003", ok, a_reg, pc); end
        wait_ram_req(10, ok);
        checks++; if (ok !== 1'b1) begin
            errors++; $display("FAIL mw_req: ram_req never seen, exp 1"); end
        n = 0;
        stable = 1'b1;
        while (ram_req === 1'b1 && n < 20) begin
            if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 15'h0064, 16'h0006}) stable = 1'b0;
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 4) begin
            errors++; $display("FAIL mw_len: req cycles got %0d exp 4", n); end
        checks++; if (stable !== 1'b1) begin
            errors++; $display("FAIL mw_stable: got %b exp 1", stable); end
        checks++; if ({retired, pc, ram_req} !== {1'b1, 15'h0004, 1'b0}) begin
            errors++; $display("FAIL mw_done: ret %b pc %h req %b exp 1 0004 0", retired, pc, ram_req); end
        checks++; if ({wr_addr, wr_data} !== {15'h0064, 16'h0006}) begin
            errors++; $display("FAIL mw_data: addr %h data %h exp 0064 0006", wr_addr, wr_data); end
        ram_lat = 0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        clear_rom();
        rom[0] = 16'h0001; rom[1] = 16'h0002; rom[2] = 16'h0003;
        do_reset();
        run = 1'b1;
        wait_retire(20, ok, n);
        wait_retire(20, ok, n);
        checks++; if ({ok, n} !== {1'b1, 32'd3}) begin
            errors++; $display("FAIL b2b_spacing: ok %b cycles %0d exp 1 3", ok, n); end
        run = 1'b0;
        wait_retire(20, ok, n);
        checks++; if ({ok, n, a_reg, pc} !== {1'b1, 32'd3, 16'h0003, 15'h0003}) begin
            errors++; $display("FAIL b2b_inflight: ok %b n %0d a %h pc %h exp 1 3 0003 0003", ok, n, a_reg, pc); end
        n = 0;
        repeat (5) begin @(negedge clk); if (rom_req === 1'b1) n++; end
        checks++; if (n !== 0) begin
            errors++; $display("FAIL b2b_stop: fetch cycles got %0d exp 0", n); end
    endtask

    task automatic test_jump_halt();
        bit ok;
        int n;
        clear_rom();
        rom[0] = 16'h0007; rom[1] = 16'hE302;
        rom[7] = 16'hEFD0; rom[8] = 16'h0007; rom[9] = 16'hE302;
        rom[10] = 16'h000A; rom[11] = 16'hEA87;
        do_reset();
        run = 1'b1;
        run_n(2, ok);
        checks++; if ({ok, pc} !== {1'b1, 15'h0007}) begin
            errors++; $display("FAIL jeq_taken: ok %b pc %h exp 1 0007", ok, pc); end
        run_n(1, ok);
        checks++; if ({ok, d_reg, pc} !== {1'b1, 16'h0001, 15'h0008}) begin
            errors++; $display("FAIL d_one: ok %b d %h pc %h exp 1 0001 0008", ok, d_reg, pc); end
        run_n(2, ok);
        checks++; if ({ok, pc} !== {1'b1, 15'h000A}) begin
            errors++; $display("FAIL jeq_not_taken: ok %b pc %h exp 1 000a", ok, pc); end
        run_n(2, ok);
        checks++; if ({ok, halted, err, pc} !== {1'b1, 1'b1, 1'b0, 15'h000A}) begin
            errors++; $display("FAIL halt: ok %b halted %b err %b pc %h exp 1 1 0 000a", ok, halted, err, pc); end
        n = 0;
        repeat (10) begin @(negedge clk); if (rom_req === 1'b1 || retired === 1'b1) n++; end
        checks++; if ({n, halted} !== {32'd0, 1'b1}) begin
            errors++; $display("FAIL halt_sticky: activity %0d halted %b exp 0 1", n, halted); end
    endtask

    task automatic test_mem_read();
        bit ok;
        int n;
        clear_rom();
        rom[0] = 16'h0020; rom[1] = 16'hFC10;
        ram_val = 16'h1234;
        ram_lat = 1;
        do_reset();
        run = 1'b1;
        wait_ram_req(20, ok);
        checks++; if ({ok, ram_we, ram_addr} !== {1'b1, 1'b0, 15'h0020}) begin
            errors++; $display("FAIL mr_req: ok %b we %b addr %h exp 1 0 0020", ok, ram_we, ram_addr); end
        wait_retire(20, ok, n);
        checks++; if ({ok, d_reg, pc} !== {1'b1, 16'h1234, 15'h0002}) begin
            errors++; $display("FAIL mr_result: ok %b d %h pc %h exp 1 1234 0002", ok, d_reg, pc); end
        ram_lat = 0;
    endtask

    task automatic test_watchdog();
        bit ok;
        int n;
        clear_rom();
        rom_en = 1'b0;
        do_reset();
        run = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rom_req === 1'b1) begin ok = 1'b1; break; end
        end
        n = 0;
        while (rom_req === 1'b1 && n < 40) begin n++; @(negedge clk); end
        checks++; if ({ok, n} !== {1'b1, 32'd8}) begin
            errors++; $display("FAIL wd_len: ok %b req cycles %0d exp 1 8", ok, n); end
        checks++; if ({err, rom_req, halted} !== 3'b100) begin
            errors++; $display("FAIL wd_err: err/req/halted got %b exp 100", {err, rom_req, halted}); end
        repeat (3) @(negedge clk);
        checks++; if ({err, rom_req} !== 2'b10) begin
            errors++; $display("FAIL wd_sticky: err/req got %b exp 10", {err, rom_req}); end
        rom_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_rom();
        rom[0] = 16'h0005; rom[1] = 16'hE308;
        ram_lat = 6;
        do_reset();
        run = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ram_req === 1'b1 && ram_we === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (ok !== 1'b1) begin
            errors++; $display("FAIL rm_reach: MEM_WR never seen, exp 1"); end
        reset = 1'b0;
        #1;
        checks++; if ({ram_req, ram_we, ram_addr, ram_wdata} !== 33'h0) begin
            errors++; $display("FAIL rm_ram: req %b we %b addr %h wdata %h exp 0", ram_req, ram_we, ram_addr, ram_wdata); end
        checks++; if ({pc, a_reg, d_reg, retired, rom_req} !== 49'h0) begin
            errors++; $display("FAIL rm_regs: pc %h a %h d %h ret %b req %b exp 0", pc, a_reg, d_reg, retired, rom_req); end
        @(negedge clk);
        reset = 1'b1;
        ram_lat = 0;
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_a_instr();
        test_alu_ctrl();
        test_mem_write();
        test_back_to_back();
        test_jump_halt();
        test_mem_read();
        test_watchdog();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hack_cpu_seq.md
Name: hack_cpu_seq

Overview:
- Multi-cycle sequencer for the Hack CPU datapath.
- Fetches 16-bit instructions over a ROM request/ack port and holds the A, D and PC registers.
- Drives the shared combinational Hack ALU: operands, zx/nx/zy/ny/f/no, and consumes out/zr/ng.
- Performs RAM read/write for M operands over a request/ack port. Sits between the top level and the ALU and memory blocks.

Parameters:
- TIMEOUT, 255: maximum wait cycles for any ack; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  allow new instruction fetches
- rom_req  out  1  instruction fetch request
- rom_addr  out  15  fetch address (= pc)
- rom_data  in  16  instruction word
- rom_ack  in  1  fetch complete; rom_data valid this cycle
- ram_req  out  1  data memory request
- ram_we  out  1  1 = write, 0 = read
- ram_addr  out  15  data address
- ram_wdata  out  16  write data
- ram_rdata  in  16  read data, valid with ram_ack
- ram_ack  in  1  data access complete
- alu_x, alu_y  out  16  ALU operands
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1  ALU control
- alu_out  in  16  ALU result
- alu_zr, alu_ng  in  1  ALU flags
- pc  out  15  program counter
- a_reg, d_reg  out  16  architectural registers
- retired  out  1  one-cycle pulse per completed instruction
- halted  out  1  self-loop detected
- err  out  1  ack timeout

Behaviour:
- Reset (async, active-low): all outputs, registers and IR = 0; state IDLE. Asserting reset mid-handshake drops req at once, with no completion.
- States: IDLE, FETCH, DECODE, MEM_RD, EXEC, MEM_WR, HALT.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: rom_req=1, rom_addr=pc, held stable until rom_ack. On ack: IR <= rom_data, rom_req drops, go to DECODE.
- DECODE, A-instruction (IR[15]=0):
  - A <= IR, pc <= pc+1, retired pulse.
  - Next state FETCH if run else IDLE.
  - Minimum 3 cycles per A-instruction with zero-wait ROM.
- DECODE, C-instruction: IR[14:13] ignored. If a-bit IR[12]=1, go to MEM_RD; else EXEC.
- MEM_RD: ram_req=1, ram_we=0, ram_addr=A[14:0] until ram_ack. M <= ram_rdata, go to EXEC.
- EXEC:
  - Operands: alu_x=D; alu_y = IR[12] ? M : A.
  - Control bits: {zx,nx,zy,ny,f,no} = IR[11:6].
  - R <= alu_out; flags captured; oldA <= A.
  - Dest IR[5]=A: A <= R. Dest IR[4]=D: D <= R. These update at the end of EXEC.
  - If IR[3] (M) is set, go to MEM_WR; else complete.
  - Outside EXEC, the ALU operand and control outputs are 0.
- MEM_WR: ram_req=1, ram_we=1, ram_addr=oldA[14:0], ram_wdata=R, held until ram_ack, then complete.
- Complete (C-instruction):
  - jmp = (j1&ng) | (j2&zr) | (j3&~ng&~zr), with j1..j3 = IR[2:0].
  - pc <= jmp ? oldA[14:0] : pc+1. pc wraps 0x7FFF -> 0.
  - retired pulse.
  - If jmp, the previous instruction was an A-instruction, and target == that instruction's pc: halted=1, state HALT.
  - Otherwise next state FETCH if run else IDLE.
- M address and jump target always use A as it was before this instruction's dest write.
- run=0 never aborts an instruction in flight; it only blocks the next fetch.
- ack while the matching req=0 is ignored.
- Watchdog: counter resets on entry to each wait state. If ack is not received after TIMEOUT cycles: err=1, req deasserted, state HALT.
- HALT is sticky until reset.

Decomposition:
- hack_pkg holds:
  - the state enum;
  - IR field constants: IS_C=15, ABIT=12, COMP_MSB/LSB=11/6, DEST_A/D/M=5/4/3, JMP_LT/EQ/GT=2/1/0;
  - the width localparams (16/15).
- Sub-module hack_jump_eval: combinational jump-condition evaluator. Inputs jbits, zr, ng; output jmp.

Test Plan:
- A-instruction: ROM[0]=0x0005, 0-wait ack -> A=0x0005, pc=1, retired after 3 cycles; rom_req low during DECODE.
- ALU control: then ROM[1]=0xEDD0 (D=A+1) -> during EXEC alu_zx..no=1,1,0,1,1,1, alu_y=5; D=0x0006, pc=2.
- Memory write with slow ack: @100 (0x0064), then 0xE308 (M=D) with ram_ack delayed 3 cycles -> ram_req/we=1, ram_addr=0x064, ram_wdata=0x0006 stable all 4 cycles, then drop.
- Conditional jump: D=0, @7, 0xE302 (D;JEQ) -> pc=7. Repeat with D=1 -> pc=pc+1. Check the M-read path: 0xFC10 (D=M) with ram_rdata=0x1234 -> D=0x1234.
- Self-loop halt: pc=10: 0x000A, pc=11: 0xEA87 (0;JMP) -> halted=1, state HALT, no further rom_req.
- Watchdog and reset: TIMEOUT=8, rom_ack never asserted -> err=1 after 8 wait cycles, rom_req=0. Separate run: reset low during MEM_WR -> ram_req=0 the same cycle; all outputs 0.
